peridot_conf_layer: RTL and testbench

PERIDOT_CONF_LAYER -- requirements
Module: peridot_conf_layer

---
 rtl/peridot_conf_layer.sv | 170 +++++++++++++++++
 tb/tb_peridot_conf_layer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/peridot_conf_layer.sv
// peridot_conf_layer: byte-stream parser that splits payload, escapes and
// config commands, plus a small output FIFO and an upstream response merger.
//
// Ports:
//   clock_sig, reset_sig          clock, async active-high reset
//   in_valid/in_ready/in_data     upstream byte stream (parser input)
//   out_valid/out_ready/out_data  decoded payload (FWFT FIFO output)
//   pk_valid/pk_ready/pk_data     downstream packets to pass upstream
//   resp_valid/resp_ready/resp_data  merged upstream return channel
//   i2c_scl_o/i2c_sda_o/i2c_sda_i    open-drain I2C, 1 = release
//   conf_bits                     user configuration nibble
module peridot_conf_layer #(
  parameter logic [7:0] CMD_CODE   = 8'h3A,
  parameter logic [7:0] ESC_CODE   = 8'h3D,
  parameter logic [7:0] ESC_XOR    = 8'h20,
  parameter int         FIFO_DEPTH = 4,
  parameter int         RESP_MAX   = 3,
  parameter logic [3:0] RESP_ID    = 4'h7
) (
  input  logic       clock_sig,
  input  logic       reset_sig,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  input  logic       pk_valid,
  output logic       pk_ready,
  input  logic [7:0] pk_data,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic [7:0] resp_data,
  output logic       i2c_scl_o,
  output logic       i2c_sda_o,
  input  logic       i2c_sda_i,
  output logic [3:0] conf_bits
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [3:0]    PEND_MAX = 4'(RESP_MAX);

  typedef enum logic [1:0] {
    P_DATA = 2'd0,
    P_CMD  = 2'd1,
    P_ESC  = 2'd2
  } pstate_t;

  pstate_t       state_q, state_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    pend_q, pend_d;
  logic          scl_q, sda_q;
  logic [3:0]    conf_q;

  logic          fifo_full, fifo_empty;
  logic          accept, push, pop;
  logic          cmd_load, pend_inc, pend_dec;
  logic [7:0]    push_byte;

  assign fifo_full  = (cnt_q == FULL_CNT);
  assign fifo_empty = (cnt_q == '0);

  // Held low in reset so nothing is accepted against cleared state.
  assign in_ready = !reset_sig && !fifo_full && (pend_q != PEND_MAX);
  assign accept   = in_valid && in_ready;

  // Parser decode: introducers always win, regardless of current state,
  // which also abandons any half-finished escape or command.
  always_comb begin
    state_d   = state_q;
    push      = 1'b0;
    push_byte = in_data;
    cmd_load  = 1'b0;
    if (accept) begin
      if (in_data == CMD_CODE) begin
        state_d = P_CMD;
      end else if (in_data == ESC_CODE) begin
        state_d = P_ESC;
      end else begin
        state_d = P_DATA;
        unique case (state_q)
          P_DATA: push = 1'b1;
          P_ESC: begin
            push      = 1'b1;
            push_byte = in_data ^ ESC_XOR;
          end
          P_CMD:  cmd_load = 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign pend_inc = cmd_load;
  assign pend_dec = resp_ready && (pend_q != 4'd0);
  assign pend_d   = pend_q + {3'b000, pend_inc} - {3'b000, pend_dec};

  // Parser state and registered I2C / config outputs.
  always_ff @(posedge clock_sig or posedge reset_sig) begin
    if (reset_sig) begin
      state_q <= P_DATA;
      pend_q  <= 4'd0;
      scl_q   <= 1'b1;
      sda_q   <= 1'b1;
      conf_q  <= 4'h0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      if (cmd_load) begin
        scl_q  <= in_data[4];
        sda_q  <= in_data[5];
        conf_q <= in_data[3:0];
      end
    end
  end

  // FWFT FIFO: head entry is always presented; pointers wrap naturally
  // because the depth is a power of two.
  assign out_valid = !fifo_empty;
  assign out_data  = mem_q[rptr_q];
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clock_sig) begin
    if (push) begin
      mem_q[wptr_q] <= push_byte;
    end
  end

  always_ff @(posedge clock_sig or posedge reset_sig) begin
    if (reset_sig) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + AW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Pending responses take priority over the packet pass-through.
  always_comb begin
    if (pend_q != 4'd0) begin
      resp_valid = 1'b1;
      resp_data  = {2'b00, i2c_sda_i && sda_q, scl_q, RESP_ID};
      pk_ready   = 1'b0;
    end else begin
      resp_valid = pk_valid;
      resp_data  = pk_data;
      pk_ready   = resp_ready;
    end
  end

  assign i2c_scl_o = scl_q;
  assign i2c_sda_o = sda_q;
  assign conf_bits = conf_q;

endmodule

// File: tb/tb_peridot_conf_layer.sv
// tb_peridot_conf_layer: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based behavioural model.
module tb_peridot_conf_layer;

  localparam int         DEPTH = 4;
  localparam int         RMAX  = 3;
  localparam logic [3:0] RID   = 4'h7;

  logic       clock_sig, reset_sig;
  logic       in_valid, in_ready;
  logic [7:0] in_data;
  logic       out_valid, out_ready;
  logic [7:0] out_data;
  logic       pk_valid, pk_ready;
  logic [7:0] pk_data;
  logic       resp_valid, resp_ready;
  logic [7:0] resp_data;
  logic       i2c_scl_o, i2c_sda_o, i2c_sda_i;
  logic [3:0] conf_bits;

  int ntests = 0;
  int nfail  = 0;

  peridot_conf_layer dut (
    .clock_sig (clock_sig),
    .reset_sig (reset_sig),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .pk_valid  (pk_valid),
    .pk_ready  (pk_ready),
    .pk_data   (pk_data),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data (resp_data),
    .i2c_scl_o (i2c_scl_o),
    .i2c_sda_o (i2c_sda_o),
    .i2c_sda_i (i2c_sda_i),
    .conf_bits (conf_bits)
  );

  initial clock_sig = 1'b0;
  always #5 clock_sig = ~clock_sig;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp,
               $time);
    end
  endtask

  // Behavioural model: a byte queue, a pending-response count and the
  // last command's fields; introducer bytes just set a "pending" flag.
  logic [7:0] m_q[$];
  int         m_pend;
  logic       m_scl, m_sda;
  logic [3:0] m_conf;
  bit         m_cmd, m_esc;

  function automatic bit m_rdy();
    return !reset_sig && (m_q.size() < DEPTH) && (m_pend != RMAX);
  endfunction

  always @(posedge clock_sig or posedge reset_sig) begin
    if (reset_sig) begin
      m_q.delete();
      m_pend = 0;
      m_scl  = 1'b1;
      m_sda  = 1'b1;
      m_conf = 4'h0;
      m_cmd  = 0;
      m_esc  = 0;
    end else begin
      bit acc, dec;
      acc = in_valid && m_rdy();
      dec = resp_ready && (m_pend > 0);
      if (out_ready && m_q.size() > 0) void'(m_q.pop_front());
      if (dec) m_pend--;
      if (acc) begin
        if (in_data == 8'h3A) begin
          m_cmd = 1; m_esc = 0;
        end else if (in_data == 8'h3D) begin
          m_esc = 1; m_cmd = 0;
        end else if (m_cmd) begin
          m_scl  = in_data[4];
          m_sda  = in_data[5];
          m_conf = in_data[3:0];
          m_pend++;
          m_cmd  = 0;
        end else if (m_esc) begin
          m_q.push_back(in_data ^ 8'h20);
          m_esc = 0;
        end else begin
          m_q.push_back(in_data);
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock_sig) begin
    logic [7:0] er;
    er = (m_pend > 0) ? {2'b00, i2c_sda_i & m_sda, m_scl, RID} : pk_data;
    chk("cyc_in_ready", in_ready, m_rdy());
    chk("cyc_out_valid", out_valid, m_q.size() > 0);
    if (m_q.size() > 0) chk("cyc_out_data", out_data, m_q[0]);
    chk("cyc_resp_valid", resp_valid, (m_pend > 0) ? 1'b1 : pk_valid);
    chk("cyc_resp_data", resp_data, er);
    chk("cyc_pk_ready", pk_ready, (m_pend > 0) ? 1'b0 : resp_ready);
    chk("cyc_scl", i2c_scl_o, m_scl);
    chk("cyc_sda", i2c_sda_o, m_sda);
    chk("cyc_conf", conf_bits, m_conf);
  end

  task automatic tick();
    @(posedge clock_sig);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      ntests++;
      nfail++;
      $display("FAIL push_timeout byte=%0h", b);
    end else begin
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    reset_sig  = 1'b1;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    out_ready  = 1'b1;
    pk_valid   = 1'b1;
    pk_data    = 8'h99;
    resp_ready = 1'b0;
    i2c_sda_i  = 1'b1;
    #3;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b1);
    chk("rst_resp_data", resp_data, 8'h99);
    chk("rst_scl", i2c_scl_o, 1'b1);
    chk("rst_sda", i2c_sda_o, 1'b1);
    chk("rst_conf", conf_bits, 4'h0);
    tick();
    tick();
    reset_sig = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1'b1);
    pk_valid = 1'b0;

    // Payload with one escaped byte.
    push(8'h41);
    chk("s1_v41", out_valid, 1'b1);
    chk("s1_d41", out_data, 8'h41);
    push(8'h3D);
    chk("s1_esc_nopush", out_valid, 1'b0);
    push(8'h1D);
    chk("s1_d3D", out_data, 8'h3D);
    push(8'h42);
    chk("s1_d42", out_data, 8'h42);
    tick();

    // Config command and its single response.
    pk_valid = 1'b1;
    pk_data  = 8'hAB;
    push(8'h3A);
    push(8'h30);
    chk("s2_scl", i2c_scl_o, 1'b1);
    chk("s2_sda", i2c_sda_o, 1'b1);
    chk("s2_conf", conf_bits, 4'h0);
    resp_ready = 1'b1;
    #1;
    chk("s2_resp_v", resp_valid, 1'b1);
    chk("s2_resp_d", resp_data, 8'h37);
    chk("s2_pk_rdy", pk_ready, 1'b0);
    tick();
    chk("s2_pass_d", resp_data, 8'hAB);
    chk("s2_pass_rdy", pk_ready, 1'b1);
    resp_ready = 1'b0;
    pk_valid   = 1'b0;

    // FIFO full back-pressure and in-order drain.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
    chk("s3_full", in_ready, 1'b0);
    chk("s3_head", out_data, 8'hA0);
    in_valid = 1'b1;
    in_data  = 8'hA4;
    for (int i = 0; i < 3; i++) begin
      chk("s3_blocked", in_ready, 1'b0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("s3_drain_v", out_valid, 1'b1);
      chk("s3_drain_d", out_data, 8'hA0 + 8'(i));
      tick();
    end
    chk("s3_empty", out_valid, 1'b0);
    push(8'hA4);
    chk("s3_fifth", out_data, 8'hA4);
    tick();

    // Pending-response limit.
    for (int i = 0; i < 3; i++) begin
      push(8'h3A);
      push(8'h00);
    end
    chk("s4_limit", in_ready, 1'b0);
    chk("s4_scl0", i2c_scl_o, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h3A;
    tick();
    tick();
    in_valid   = 1'b0;
    pk_valid   = 1'b1;
    pk_data    = 8'h5C;
    resp_ready = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("s4_resp_v", resp_valid, 1'b1);
      chk("s4_resp_d", resp_data, 8'h07);
      chk("s4_pk_blk", pk_ready, 1'b0);
      tick();
    end
    chk("s4_pass_d", resp_data, 8'h5C);
    chk("s4_pass_rdy", pk_ready, 1'b1);
    chk("s4_rdy_back", in_ready, 1'b1);
    pk_valid   = 1'b0;
    resp_ready = 1'b0;

    // Escape abandoned by a command introducer.
    push(8'h3D);
    push(8'h3A);
    push(8'h10);
    chk("s5_nopush", out_valid, 1'b0);
    chk("s5_scl", i2c_scl_o, 1'b1);
    chk("s5_sda", i2c_sda_o, 1'b0);
    chk("s5_resp", resp_data, 8'h17);
    resp_ready = 1'b1;
    tick();
    chk("s5_done", resp_valid, 1'b0);
    resp_ready = 1'b0;

    // Reset mid-stream.
    out_ready = 1'b0;
    push(8'h11);
    push(8'h22);
    push(8'h3A);
    push(8'h00);
    chk("s6_queued", out_valid, 1'b1);
    chk("s6_sda_low", i2c_sda_o, 1'b0);
    pk_valid = 1'b1;
    #1;
    reset_sig = 1'b1;
    #1;
    chk("s6_out_v", out_valid, 1'b0);
    chk("s6_in_rdy", in_ready, 1'b0);
    chk("s6_resp_v1", resp_valid, 1'b1);
    chk("s6_scl", i2c_scl_o, 1'b1);
    chk("s6_sda", i2c_sda_o, 1'b1);
    pk_valid   = 1'b0;
    resp_ready = 1'b1;
    #1;
    chk("s6_resp_v0", resp_valid, 1'b0);
    chk("s6_pk_rdy", pk_ready, 1'b1);
    tick();
    reset_sig = 1'b0;
    #1;
    chk("s6_rdy_up", in_ready, 1'b1);
    chk("s6_still_empty", out_valid, 1'b0);

    // Randomized traffic, with one reset in the middle.
    for (int c = 0; c < 3000; c++) begin
      int r;
      tick();
      r = $urandom_range(0, 15);
      in_valid   = ($urandom_range(0, 3) != 0);
      in_data    = (r < 2) ? 8'h3A : (r < 4) ? 8'h3D : 8'($urandom);
      out_ready  = ($urandom_range(0, 4) > 1);
      resp_ready = ($urandom_range(0, 2) == 0);
      pk_valid   = $urandom_range(0, 1);
      pk_data    = 8'($urandom);
      i2c_sda_i  = $urandom_range(0, 1);
      if (c == 1500) reset_sig = 1'b1;
      if (c == 1503) reset_sig = 1'b0;
    end
    in_valid = 1'b0;
    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
